// File: rtl/taco_order_queue_if.sv
// Taco order queue handshake bundle: raw buttons and serve in, head order and
// queue status out. DEPTH sizes the level field and must match the queue.
interface taco_order_queue_if #(
  parameter int DEPTH = 8
) ();
  logic [3:0]             btn;
  logic                   serve;
  logic [3:0]             sel;
  logic                   valid;
  logic [$clog2(DEPTH):0] level;
  logic                   full;
  logic                   err;
  logic [7:0]             total;

  modport master (
    output btn, serve,
    input  sel, valid, level, full, err, total
  );

  modport slave (
    input  btn, serve,
    output sel, valid, level, full, err, total
  );
endinterface

// File: rtl/taco_order_queue.sv
// Taco order queue: synchronised one-hot button orders into a FIFO.
// Optional TACO_TOTALS_EN enables the saturating accepted-order counter.
module taco_order_queue #(
  parameter int DEPTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  taco_order_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [3:0]    s1, s2, s3;
  logic [3:0]    arm;
  logic          primed;
  logic [3:0]    rise;
  logic          one;
  logic          multi;
  logic          pop;
  logic          push;
  logic          rej;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW:0]   level_q;
  logic [AW:0]   level_nxt;
  logic          valid_q;
  logic          full_q;
  logic          err_q;

  // arm stays low until a bit is truly seen released after reset,
  // so a button held through reset cannot fake a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      s2     <= '0;
      s3     <= '0;
      arm    <= '0;
      primed <= 1'b0;
    end else begin
      s1     <= q.btn;
      s2     <= s1;
      s3     <= s2;
      primed <= 1'b1;
      arm    <= arm | ({4{primed}} & ~s1);
    end
  end

  assign rise = s2 & ~s3 & arm;

  always_comb begin
    one = 1'b0;
    unique case (rise)
      4'b0001,
      4'b0010,
      4'b0100,
      4'b1000: one = 1'b1;
      default: one = 1'b0;
    endcase
  end

  assign multi = (|rise) & ~one;
  assign pop   = q.serve & valid_q;
  assign push  = one & (~full_q | pop);
  assign rej   = one & ~push;

  always_comb begin
    level_nxt = level_q;
    unique case ({push, pop})
      2'b10:   level_nxt = level_q + LVL_ONE;
      2'b01:   level_nxt = level_q - LVL_ONE;
      default: level_nxt = level_q;
    endcase
  end

  // Entries need no reset: sel is gated by valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= rise;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr    <= '0;
      wptr    <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      level_q <= level_nxt;
      valid_q <= (level_nxt != '0);
      full_q  <= (level_nxt == LVL_MAX);
      err_q   <= multi | rej;
    end
  end

  assign q.sel   = valid_q ? mem[rptr] : 4'b0000;
  assign q.valid = valid_q;
  assign q.level = level_q;
  assign q.full  = full_q;
  assign q.err   = err_q;

`ifdef TACO_TOTALS_EN
  logic [7:0] total_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= 8'd0;
    end else if (push && total_q != 8'hFF) begin
      total_q <= total_q + 8'd1;
    end
  end

  assign q.total = total_q;
`else
  assign q.total = 8'd0;
`endif

endmodule

// File: tb/tb_taco_order_queue.sv
// Randomised self-checking bench for taco_order_queue against a
// behavioural order-queue model.
module tb_taco_order_queue;
  localparam int DEPTH = 8;
  localparam int LW = $clog2(DEPTH) + 1;
`ifdef TACO_TOTALS_EN
  localparam bit TOT_EN = 1'b1;
  localparam logic [7:0] TOT_FINAL = 8'd255;
`else
  localparam bit TOT_EN = 1'b0;
  localparam logic [7:0] TOT_FINAL = 8'd0;
`endif

  typedef logic [LW+14:0] obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  taco_order_queue_if #(.DEPTH(DEPTH)) qi ();

  taco_order_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (qi)
  );

  // Model: queue of orders; button samples taken at each clk edge.
  logic [3:0] m_q[$];
  logic [3:0] hist[$];
  logic       m_err;
  int         m_total;
  int         m_accepted;

  task automatic model_reset();
    m_q.delete();
    // Before reset release every button counts as held.
    hist = '{4'hF, 4'hF, 4'hF};
    m_err = 1'b0;
    m_total = 0;
  endtask

  // An order is taken at the edge where the sample two edges back is
  // high and the one three edges back was low.
  task automatic step(input logic [3:0] b, input logic s);
    logic [3:0] r;
    int cnt;
    bit pp, ps;
    qi.btn = b;
    qi.serve = s;
    @(posedge clk);
    r = hist[1] & ~hist[0];
    cnt = $countones(r);
    pp = s && (m_q.size() > 0);
    ps = (cnt == 1) && ((m_q.size() < DEPTH) || pp);
    m_err = (cnt > 1) || ((cnt == 1) && !ps);
    if (pp) void'(m_q.pop_front());
    if (ps) begin
      m_q.push_back(r);
      m_accepted++;
      if (m_total < 255) m_total++;
    end
    hist.push_back(b);
    void'(hist.pop_front());
    #1;
  endtask

  function automatic obs_t exp_obs();
    logic [3:0] hd;
    logic [7:0] tt;
    hd = (m_q.size() > 0) ? m_q[0] : 4'b0000;
    tt = TOT_EN ? 8'(m_total) : 8'd0;
    return {m_q.size() > 0, m_q.size() == DEPTH, m_err,
            LW'(m_q.size()), hd, tt};
  endfunction

  function automatic obs_t dut_obs();
    return {qi.valid, qi.full, qi.err, qi.level, qi.sel, qi.total};
  endfunction

  function automatic logic [3:0] rand_bit();
    return 4'(1 << $urandom_range(0, 3));
  endfunction

  task automatic test_reset();
    qi.btn = 4'b0000;
    qi.serve = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_obs() !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %h want 0", dut_obs());
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 1'b0);
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_bad++;
        $display("FAIL reset_idle: got %h want %h", dut_obs(), exp_obs());
      end
    end
  endtask

  task automatic test_single_press();
    for (int i = 0; i < 5; i++) begin
      step(4'b0001, 1'b0);
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_bad++;
        $display("FAIL single_press: got %h want %h", dut_obs(), exp_obs());
      end
      if (i == 1) begin
        n_cmp++;
        if (qi.valid !== 1'b0) begin
          n_bad++;
          $display("FAIL single_early: got valid=%b want 0", qi.valid);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if ({qi.valid, qi.sel, qi.level, qi.err} !== {1'b1, 4'b0001, LW'(1), 1'b0}) begin
          n_bad++;
          $display("FAIL single_third_edge: got v=%b sel=%b lvl=%0d err=%b want 1 0001 1 0",
                   qi.valid, qi.sel, qi.level, qi.err);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 1'b1);
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_bad++;
        $display("FAIL single_drain: got %h want %h", dut_obs(), exp_obs());
      end
    end
  endtask

  task automatic test_fifo_order();
    logic [3:0] codes [3];
    codes = '{4'b0010, 4'b1000, 4'b0100};
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 5; c++) begin
        step((c < 3) ? codes[k] : 4'b0000, 1'b0);
        n_cmp++;
        if (dut_obs() !== exp_obs()) begin
          n_bad++;
          $display("FAIL fifo_fill: got %h want %h", dut_obs(), exp_obs());
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (qi.sel !== codes[k]) begin
        n_bad++;
        $display("FAIL fifo_head%0d: got %b want %b", k, qi.sel, codes[k]);
      end
      step(4'b0000, 1'b1);
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_bad++;
        $display("FAIL fifo_serve: got %h want %h", dut_obs(), exp_obs());
      end
    end
    n_cmp++;
    if ({qi.valid, qi.sel} !== 5'b0) begin
      n_bad++;
      $display("FAIL fifo_empty: got v=%b sel=%b want 0 0000", qi.valid, qi.sel);
    end
  endtask

  task automatic test_multi();
    int errs;
    errs = 0;
    for (int c = 0; c < 6; c++) begin
      step((c < 3) ? 4'b0011 : 4'b0000, 1'b0);
      if (qi.err === 1'b1) errs++;
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_bad++;
        $display("FAIL multi: got %h want %h", dut_obs(), exp_obs());
      end
    end
    n_cmp++;
    if (errs != 1 || qi.level !== LW'(0)) begin
      n_bad++;
      $display("FAIL multi_pulse: got err_cycles=%0d lvl=%0d want 1 0", errs, qi.level);
    end
  endtask

  task automatic test_full();
    int errs;
    logic [3:0] b;
    for (int p = 0; p < DEPTH + 1; p++) begin
      b = rand_bit();
      step(b, 1'b0);
      step(4'b0000, 1'b0);
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_bad++;
        $display("FAIL full_fill: got %h want %h", dut_obs(), exp_obs());
      end
    end
    step(4'b0000, 1'b0);
    n_cmp++;
    if ({qi.full, qi.level} !== {1'b1, LW'(DEPTH)}) begin
      n_bad++;
      $display("FAIL full_flag: got full=%b lvl=%0d want 1 %0d", qi.full, qi.level, DEPTH);
    end
    errs = 0;
    b = rand_bit();
    for (int c = 0; c < 4; c++) begin
      step((c == 0) ? b : 4'b0000, 1'b0);
      if (qi.err === 1'b1) errs++;
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_bad++;
        $display("FAIL full_drop: got %h want %h", dut_obs(), exp_obs());
      end
    end
    n_cmp++;
    if (errs != 1 || qi.level !== LW'(DEPTH)) begin
      n_bad++;
      $display("FAIL full_drop_err: got err_cycles=%0d lvl=%0d want 1 %0d", errs, qi.level, DEPTH);
    end
    b = rand_bit();
    step(b, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    n_cmp++;
    if ({qi.err, qi.level} !== {1'b0, LW'(DEPTH)}) begin
      n_bad++;
      $display("FAIL full_pushpop: got err=%b lvl=%0d want 0 %0d", qi.err, qi.level, DEPTH);
    end
    n_cmp++;
    if (dut_obs() !== exp_obs()) begin
      n_bad++;
      $display("FAIL full_pushpop_model: got %h want %h", dut_obs(), exp_obs());
    end
    for (int c = 0; c < DEPTH + 1; c++) begin
      step(4'b0000, 1'b1);
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_bad++;
        $display("FAIL full_drain: got %h want %h", dut_obs(), exp_obs());
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int p = 0; p < 3; p++) begin
      step(rand_bit(), 1'b0);
      step(4'b0000, 1'b0);
    end
    step(4'b0000, 1'b0);
    n_cmp++;
    if (qi.level !== LW'(3)) begin
      n_bad++;
      $display("FAIL rstmid_fill: got lvl=%0d want 3", qi.level);
    end
    qi.btn = 4'b0100;
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_obs() !== '0) begin
      n_bad++;
      $display("FAIL rstmid_async: got %h want 0", dut_obs());
    end
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(4'b0100, 1'b0);
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_bad++;
        $display("FAIL rstmid_held: got %h want %h", dut_obs(), exp_obs());
      end
    end
    n_cmp++;
    if (qi.level !== LW'(0)) begin
      n_bad++;
      $display("FAIL rstmid_no_order: got lvl=%0d want 0", qi.level);
    end
    for (int c = 0; c < 6; c++) begin
      step((c >= 2 && c < 5) ? 4'b0100 : 4'b0000, 1'b0);
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_bad++;
        $display("FAIL rstmid_repress: got %h want %h", dut_obs(), exp_obs());
      end
    end
    n_cmp++;
    if ({qi.level, qi.sel} !== {LW'(1), 4'b0100}) begin
      n_bad++;
      $display("FAIL rstmid_new_order: got lvl=%0d sel=%b want 1 0100", qi.level, qi.sel);
    end
  endtask

  task automatic test_random();
    logic [3:0] b;
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 3))
        0: b = 4'($urandom_range(0, 15));
        1: b = 4'b0000;
        default: b = rand_bit();
      endcase
      step(b, $urandom_range(0, 2) != 0);
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_bad++;
        $display("FAIL random: got %h want %h", dut_obs(), exp_obs());
      end
    end
  endtask

  task automatic test_totals();
    int start;
    start = m_accepted;
    for (int c = 0; c < 2000 && (m_accepted - start) < 260; c++) begin
      step(c[0] ? 4'b0000 : rand_bit(), $urandom_range(0, 3) != 0);
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_bad++;
        $display("FAIL totals_run: got %h want %h", dut_obs(), exp_obs());
      end
    end
    n_cmp++;
    if ((m_accepted - start) < 260 || qi.total !== TOT_FINAL) begin
      n_bad++;
      $display("FAIL totals_final: got total=%0d accepted=%0d want %0d and >=260",
               qi.total, m_accepted - start, TOT_FINAL);
    end
  endtask

  initial begin
    m_accepted = 0;
    qi.btn = 4'b0000;
    qi.serve = 1'b0;
    test_reset();
    test_single_press();
    test_fifo_order();
    test_multi();
    test_full();
    test_reset_mid();
    test_random();
    test_totals();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
